// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - scan-code constants and receiver state type
package ps2_pkg;

    localparam logic [7:0] SC_EXT  = 8'hE0;
    localparam logic [7:0] SC_BRK  = 8'hF0;
    localparam logic [7:0] SC_W    = 8'h1D;
    localparam logic [7:0] SC_S    = 8'h1B;
    localparam logic [7:0] SC_UP   = 8'h75;
    localparam logic [7:0] SC_DOWN = 8'h72;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 frame receiver with synchroniser, clock glitch filter and timeout
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_CYCLES - 1);
    localparam logic [TW-1:0] TOUT_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          sample_ev;

    rx_state_t     state_q, state_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tout_q, tout_d;
    logic [7:0]    code_d;
    logic          valid_d, err_d;

    // Two-flop synchronisers for the asynchronous pin inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_dat;
            dat_s2 <= dat_s1;
        end
    end

    // Filtered clock flips only after FILTER_CYCLES consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s2 == filt_clk) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_MAX) begin
            filt_clk <= clk_s2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    // The cycle in which the filtered clock accepts a falling edge
    assign sample_ev = filt_clk & ~clk_s2 & (filt_cnt == FILT_MAX);

    // Frame state, shift register, timeout counter and registered strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tout_q     <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tout_q     <= tout_d;
            code       <= code_d;
            code_valid <= valid_d;
            frame_err  <= err_d;
        end
    end

    // Next-state logic: start, 8 data bits LSB first, odd parity, stop
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        code_d  = code;
        valid_d = 1'b0;
        err_d   = 1'b0;
        tout_d  = (state_q == IDLE || sample_ev) ? '0 : tout_q + TW'(1);

        case (state_q)
            IDLE: begin
                if (sample_ev && !dat_s2) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (sample_ev) begin
                    shift_d = {dat_s2, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = PARITY;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (sample_ev) begin
                    par_d   = dat_s2;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (sample_ev) begin
                    state_d = IDLE;
                    if (dat_s2 && (^{shift_q, par_q})) begin
                        code_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A stalled frame is abandoned so the next start bit is not misframed
        if (state_q != IDLE && !sample_ev && tout_q == TOUT_MAX) begin
            state_d = IDLE;
            err_d   = 1'b1;
            tout_d  = '0;
        end
    end

endmodule

// File: rtl/ps2_pad_keys.sv
// rtl/ps2_pad_keys.sv - PS/2 keyboard to active-low paddle key decoder
module ps2_pad_keys
    import ps2_pkg::*;
#(
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [1:0] keys_left,
    output logic [1:0] keys_right,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    logic ext, brk;

    ps2_rx #(
        .FILTER_CYCLES  (FILTER_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .code       (code),
        .code_valid (code_valid),
        .frame_err  (frame_err)
    );

    // Prefix tracking and key update; a broken frame drops any pending prefix
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext        <= 1'b0;
            brk        <= 1'b0;
            keys_left  <= 2'b11;
            keys_right <= 2'b11;
        end else if (frame_err) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (code_valid) begin
            if (code == SC_EXT) begin
                ext <= 1'b1;
            end else if (code == SC_BRK) begin
                brk <= 1'b1;
            end else begin
                case ({ext, code})
                    {1'b0, SC_W}:    keys_left[1]  <= brk;
                    {1'b0, SC_S}:    keys_left[0]  <= brk;
                    {1'b1, SC_UP}:   keys_right[1] <= brk;
                    {1'b1, SC_DOWN}: keys_right[0] <= brk;
                    default: ;
                endcase
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_pad_keys.sv
// tb/tb_ps2_pad_keys.sv - scoreboard testbench for ps2_pad_keys
module tb_ps2_pad_keys;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk, ps2_dat;
    logic [1:0] keys_left, keys_right;
    logic [7:0] code;
    logic       code_valid, frame_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         err;
        logic [7:0] code;
        logic [3:0] keys;
    } exp_t;

    exp_t exp_q[$];

    // reference: which of W, S, Up, Down are currently pressed, plus pending prefixes
    bit pressed_w, pressed_s, pressed_up, pressed_dn;
    bit saw_e0, saw_f0;

    logic       key_pend = 1'b0;
    logic [3:0] key_exp;

    ps2_pad_keys dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .keys_left  (keys_left),
        .keys_right (keys_right),
        .code       (code),
        .code_valid (code_valid),
        .frame_err  (frame_err)
    );

    always #10 clk = ~clk;

    function automatic logic [3:0] model_keys();
        return {~pressed_w, ~pressed_s, ~pressed_up, ~pressed_dn};
    endfunction

    task automatic model_reset();
        pressed_w = 0; pressed_s = 0; pressed_up = 0; pressed_dn = 0;
        saw_e0 = 0; saw_f0 = 0;
    endtask

    task automatic model_good_byte(input logic [7:0] b);
        exp_t e;
        if (b == 8'hE0) saw_e0 = 1;
        else if (b == 8'hF0) saw_f0 = 1;
        else begin
            if (!saw_e0 && b == 8'h1D) pressed_w  = !saw_f0;
            if (!saw_e0 && b == 8'h1B) pressed_s  = !saw_f0;
            if (saw_e0 && b == 8'h75)  pressed_up = !saw_f0;
            if (saw_e0 && b == 8'h72)  pressed_dn = !saw_f0;
            saw_e0 = 0; saw_f0 = 0;
        end
        e.err = 0; e.code = b; e.keys = model_keys();
        exp_q.push_back(e);
    endtask

    task automatic model_bad_frame();
        exp_t e;
        saw_e0 = 0; saw_f0 = 0;
        e.err = 1; e.code = 8'h00; e.keys = model_keys();
        exp_q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        ps2_dat = b;
        cycles(16);
        ps2_clk = 1'b0;
        cycles(16);
        ps2_clk = 1'b1;
        if (glitch) begin
            cycles(12);
            ps2_clk = 1'b0;
            cycles(3);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch);
        logic p;
        p = ~^b;
        if (bad_par) p = ~p;
        if (bad_par) model_bad_frame();
        else model_good_byte(b);
        send_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
        send_bit(p, glitch);
        send_bit(1'b1, glitch);
        ps2_dat = 1'b1;
        cycles(30);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_keys_left"}, 32'(keys_left), 32'h3);
        check({tag, "_keys_right"}, 32'(keys_right), 32'h3);
        check({tag, "_code"}, 32'(code), 32'h0);
        check({tag, "_code_valid"}, 32'(code_valid), 32'h0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    endtask

    // Monitor: every strobe pops one expectation; keys are compared the following cycle
    always @(negedge clk) begin
        if (rst) begin
            key_pend = 1'b0;
        end else begin
            if (key_pend) begin
                checks++;
                if ({keys_left, keys_right} !== key_exp) begin
                    errors++;
                    $display("FAIL keys: got %b_%b, expected %b_%b",
                             keys_left, keys_right, key_exp[3:2], key_exp[1:0]);
                end
                key_pend = 1'b0;
            end
            if (code_valid || frame_err) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: code_valid=%b frame_err=%b code=%h",
                             code_valid, frame_err, code);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.err) begin
                        if (!frame_err || code_valid) begin
                            errors++;
                            $display("FAIL frame_err: got err=%b valid=%b, expected err=1 valid=0",
                                     frame_err, code_valid);
                        end
                    end else if (!code_valid || frame_err || code !== e.code) begin
                        errors++;
                        $display("FAIL code: got valid=%b err=%b code=%h, expected valid=1 err=0 code=%h",
                                 code_valid, frame_err, code, e.code);
                    end
                    key_exp  = e.keys;
                    key_pend = 1'b1;
                end
            end
        end
    end

    initial begin
        cycles(98000);
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pool [7];
        logic [7:0] b;
        pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'h1D; pool[3] = 8'h1B;
        pool[4] = 8'h75; pool[5] = 8'h72; pool[6] = 8'h00;

        model_reset();
        rst = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1;
        cycles(5);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        cycles(20);

        // W make/break; right pad never moves
        send_frame(8'h1D, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1D, 0, 0);

        // extended Up make/break, and Up code without E0 is ignored
        send_frame(8'hE0, 0, 0);
        send_frame(8'h75, 0, 0);
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h75, 0, 0);
        send_frame(8'h75, 0, 0);

        // parity error then valid S
        send_frame(8'h1B, 1, 0);
        send_frame(8'h1B, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1B, 0, 0);

        // stalled frame: start + 4 data bits then silence
        model_bad_frame();
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'(i & 1), 0);
        ps2_dat = 1'b1;
        cycles(60000);
        check("timeout_drained", 32'(exp_q.size()), 32'h0);
        send_frame(8'h1D, 0, 0);

        // glitches in idle and within every bit of a frame
        for (int i = 0; i < 4; i++) begin
            ps2_clk = 1'b0;
            cycles(3);
            ps2_clk = 1'b1;
            cycles(20);
        end
        send_frame(8'hF0, 0, 1);
        send_frame(8'h1D, 0, 1);

        // randomized byte stream with occasional parity errors
        for (int i = 0; i < 16; i++) begin
            b = pool[$urandom_range(0, 6)];
            if (b == 8'h00) b = 8'($urandom_range(0, 255));
            send_frame(b, ($urandom_range(0, 5) == 0), 0);
        end

        // reset in the middle of a frame while W is held
        send_frame(8'h1D, 0, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        rst = 1'b1;
        #1;
        check_reset_outputs("midframe_rst");
        model_reset();
        exp_q.delete();
        ps2_clk = 1'b1; ps2_dat = 1'b1;
        cycles(5);
        rst = 1'b0;
        cycles(20);
        send_frame(8'h1B, 0, 0);

        cycles(50);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        check("final_keys", 32'({keys_left, keys_right}), 32'(model_keys()));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
